// File: rtl/ptr_pool_alloc.sv
`default_nettype none
// ============================================================================
// ptr_pool_alloc -- free-pointer pool: lowest-index allocation, multi-port
// returns with error capture, single-cycle flush.          Rev 1.0
// ============================================================================
module ptr_pool_alloc #(
  parameter int DATA_DEPTH = 16,
  parameter int PTR_WD     = $clog2(DATA_DEPTH),
  parameter int NUM_RET    = 2,
  parameter int LOW_WM     = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      alloc_vld,
  input  logic                      alloc_rdy,
  output logic [PTR_WD-1:0]         alloc_ptr,
  input  logic [NUM_RET-1:0]        ret_vld,
  input  logic [NUM_RET*PTR_WD-1:0] ret_ptr,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic [PTR_WD:0]           free_cnt,
  output logic                      all_free,
  output logic                      none_free,
  output logic                      low_wm,
  output logic                      err,
  output logic [PTR_WD-1:0]         err_ptr
);

  localparam int              c_pad_depth = 1 << PTR_WD;
  localparam logic [0:0]      c_st_run    = 1'b0;
  localparam logic [0:0]      c_st_flush  = 1'b1;
  localparam logic [PTR_WD:0] c_full_cnt  = (PTR_WD+1)'(DATA_DEPTH);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [DATA_DEPTH-1:0] r_avail;
  logic [PTR_WD:0]       r_free_cnt;
  logic                  r_err;
  logic [PTR_WD-1:0]     r_err_ptr;

  logic [c_pad_depth-1:0] w_avail_pad;
  logic [c_pad_depth-1:0] w_set_pad;
  logic [c_pad_depth-1:0] w_clr_pad;
  logic [PTR_WD-1:0]      w_rp [NUM_RET];
  logic [PTR_WD-1:0]      w_low_ptr;
  logic [PTR_WD-1:0]      w_bad_ptr;
  logic                   w_any_bad;
  logic                   w_fire;
  logic                   w_run_upd;
  int                     w_nret;
  int                     w_cnt_nxt;

  generate
    for (genvar gi = 0; gi < NUM_RET; gi++) begin : g_ret
      assign w_rp[gi] = ret_ptr[gi*PTR_WD +: PTR_WD];
    end
  endgenerate

  // Padding to a power of two lets out-of-range pointers index safely.
  assign w_avail_pad = c_pad_depth'(r_avail);

  always_comb begin
    w_low_ptr = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (r_avail[i]) w_low_ptr = PTR_WD'(i);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= c_st_run;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:   if (flush_req) w_state_nxt = c_st_flush;
      c_st_flush: w_state_nxt = c_st_run;
      default:    w_state_nxt = c_st_run;
    endcase
  end

  // FSM: outputs
  always_comb begin
    alloc_vld  = (r_state == c_st_run) && (r_free_cnt != '0) && !flush_req;
    flush_busy = (r_state == c_st_flush);
  end

  assign alloc_ptr = w_low_ptr;
  assign w_fire    = alloc_vld && alloc_rdy;
  assign w_run_upd = (r_state == c_st_run) && !flush_req;

  // A return is legal only for an allocated, in-range pointer not already
  // claimed by a lower-indexed port; the lowest offending port is reported.
  always_comb begin
    w_set_pad = '0;
    w_clr_pad = '0;
    w_nret    = 0;
    w_any_bad = 1'b0;
    w_bad_ptr = '0;
    w_clr_pad[w_low_ptr] = w_fire;
    for (int i = NUM_RET - 1; i >= 0; i--) begin
      logic dup;
      dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (ret_vld[j] && (w_rp[j] == w_rp[i])) dup = 1'b1;
      end
      if (ret_vld[i]) begin
        if ((32'(w_rp[i]) < DATA_DEPTH) && !w_avail_pad[w_rp[i]] && !dup) begin
          w_set_pad[w_rp[i]] = 1'b1;
          w_nret = w_nret + 1;
        end else begin
          w_any_bad = 1'b1;
          w_bad_ptr = w_rp[i];
        end
      end
    end
    w_cnt_nxt = int'(r_free_cnt) + w_nret - (w_fire ? 1 : 0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_avail    <= '1;
      r_free_cnt <= c_full_cnt;
      r_err      <= 1'b0;
      r_err_ptr  <= '0;
    end else if (r_state == c_st_flush) begin
      r_avail    <= '1;
      r_free_cnt <= c_full_cnt;
    end else if (w_run_upd) begin
      assert (w_cnt_nxt >= 0 && w_cnt_nxt <= DATA_DEPTH);
      r_avail    <= (r_avail & ~w_clr_pad[DATA_DEPTH-1:0]) | w_set_pad[DATA_DEPTH-1:0];
      r_free_cnt <= w_cnt_nxt[PTR_WD:0];
      if (w_any_bad) begin
        r_err <= 1'b1;
        if (!r_err) r_err_ptr <= w_bad_ptr;
      end
    end
  end

  assign free_cnt  = r_free_cnt;
  assign all_free  = (r_free_cnt == c_full_cnt);
  assign none_free = (r_free_cnt == '0);
  assign low_wm    = (int'(r_free_cnt) <= LOW_WM);
  assign err       = r_err;
  assign err_ptr   = r_err_ptr;

endmodule
`default_nettype wire
